// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands LSB first, one bit per clock, then pulse done with a registered sum/cout.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rs_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             h1_s, h1_c, h2_c, s, c;

   // Full adder built as two half-adder stages plus an OR on their carries.
   assign h1_s = ra[0] ^ rb[0];
   assign h1_c = ra[0] & rb[0];
   assign s    = h1_s ^ carry;
   assign h2_c = h1_s & carry;
   assign c    = h1_c | h2_c;

   generate
      if (WIDTH == 1) begin : g_rs_one
         assign rs_next = s;
      end else begin : g_rs_wide
         assign rs_next = {s, rs[WIDTH-1:1]};
      end
   endgenerate

   assign busy = (state == ADD);
   assign done = (state == DONE);

   // DONE accepts a new start exactly like IDLE so results can stream back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= ADD;
               end else begin
                  state <= IDLE;
               end
            end
            ADD: begin
               carry <= c;
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               rs    <= rs_next;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= rs_next;
                  cout  <= c;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start1;
   logic [7:0] a8, b8, sum8;
   logic [0:0] a1, b1, sum1;
   logic       busy8, done8, cout8;
   logic       busy1, done1, cout1;
   int         checks = 0;
   int         errors = 0;
   int         pulses;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle, then check done timing and the result.
   task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] es, input logic ec, input string tag);
      a8 = x; b8 = y; start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (7) step();
      checkOutput({tag, "_early_done"}, 32'(done8), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy8), 32'd1);
      step();
      checkOutput({tag, "_done"}, 32'(done8), 32'd1);
      checkOutput({tag, "_busy_off"}, 32'(busy8), 32'd0);
      checkOutput({tag, "_sum"}, 32'(sum8), 32'(es));
      checkOutput({tag, "_cout"}, 32'(ec), 32'(cout8) & 32'd1);
   endtask

   task automatic applyStimulus1(input logic x, input logic y, input logic [1:0] exp, input string tag);
      a1 = x; b1 = y; start1 = 1'b1;
      step();
      start1 = 1'b0;
      checkOutput({tag, "_busy"}, 32'(busy1), 32'd1);
      step();
      checkOutput({tag, "_done"}, 32'(done1), 32'd1);
      checkOutput({tag, "_sumcout"}, 32'({cout1, sum1}), 32'(exp));
      step();
   endtask

   initial begin
      rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;

      // Reset held for two cycles.
      step(); step();
      checkOutput("rst_busy", 32'(busy8), 32'd0);
      checkOutput("rst_done", 32'(done8), 32'd0);
      checkOutput("rst_sum", 32'(sum8), 32'd0);
      checkOutput("rst_cout", 32'(cout8), 32'd0);
      checkOutput("rst_w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
      rst = 1'b0;
      step();

      // Basic addition and hold while idle.
      applyStimulus8(8'd23, 8'd45, 8'd68, 1'b0, "add_23_45");
      repeat (3) step();
      checkOutput("hold_sum", 32'(sum8), 32'd68);
      checkOutput("hold_done", 32'(done8), 32'd0);
      checkOutput("hold_busy", 32'(busy8), 32'd0);

      // Carry-out cases.
      applyStimulus8(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
      step();
      applyStimulus8(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");
      step();

      // start held high, operands change during ADD; second op accepted in DONE.
      a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
      step();
      a8 = 8'd200; b8 = 8'd100;
      repeat (7) step();
      checkOutput("hold_start_early", 32'(done8), 32'd0);
      step();
      checkOutput("hold_start_done", 32'(done8), 32'd1);
      checkOutput("hold_start_sum", 32'(sum8), 32'd8);
      checkOutput("hold_start_cout", 32'(cout8), 32'd0);
      step();
      start8 = 1'b0;
      checkOutput("b2b_busy", 32'(busy8), 32'd1);
      checkOutput("b2b_sum_held", 32'(sum8), 32'd8);
      repeat (7) step();
      checkOutput("b2b_early", 32'(done8), 32'd0);
      step();
      checkOutput("b2b_done", 32'(done8), 32'd1);
      checkOutput("b2b_sum", 32'(sum8), 32'h2C);
      checkOutput("b2b_cout", 32'(cout8), 32'd1);
      step();

      // Reset at edge E+4 aborts the addition.
      a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_sum", 32'(sum8), 32'd0);
      checkOutput("abort_cout", 32'(cout8), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) pulses++;
         step();
      end
      checkOutput("abort_no_done", 32'(pulses), 32'd0);
      applyStimulus8(8'd1, 8'd1, 8'd2, 1'b0, "after_abort");
      step();

      // WIDTH=1 half-adder truth table.
      applyStimulus1(1'b0, 1'b0, 2'b00, "w1_00");
      applyStimulus1(1'b0, 1'b1, 2'b01, "w1_01");
      applyStimulus1(1'b1, 1'b0, 2'b01, "w1_10");
      applyStimulus1(1'b1, 1'b1, 2'b10, "w1_11");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
